fetch_unit: RTL and testbench
=============================

# fetch_unit

Multi-cycle instruction fetch stage for the Y86-64 core: holds the architectural PC, reads instruction bytes from an 8-byte-wide instruction memory, and splits them into icode/ifun/rA/rB/valC/valP. It sits upstream of decode/execute. It also sits upstream of updatePC, which returns the next PC on `new_pc_i`. Output is a registered valid/ready handshake, so later stages can stall fetch.

## Interface
- RESET_PC, 64'h0, PC loaded on reset
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- new_pc_i  in  64  next PC from updatePC; sampled on output acceptance
- imem_req_o  out  1  one-cycle read request pulse
- imem_addr_o  out  64  byte address of request
- imem_rvalid_i  in  1  read data valid
- imem_rdata_i  in  64  bytes addr..addr+7; byte at addr in [7:0]
- imem_err_i  in  1  address error, qualified by imem_rvalid_i
- out_valid_o  out  1  fetched instruction available
- out_ready_i  in  1  downstream accepts
- pc_o  out  64  PC of presented instruction
- icode_o / ifun_o / rA_o / rB_o  out  4 each  decoded fields
- valC_o  out  64  constant word, little-endian
- valP_o  out  64  pc_o + instruction length
- stat_o  out  3  SAOK=1, SHLT=2, SADR=3, SINS=4

## Operation
- States: REQ0, WAIT0, REQ1, WAIT1, HOLD, STOP.
- REQ0: pulse imem_req_o with addr=pc. Go to WAIT0.
- WAIT0: on rvalid, capture the word into buf0 and decode the length from byte0[7:4].
  - IHALT, INOP, IRET: length 1.
  - IRRMOVQ/ICMOVXX, IOPQ, IPUSHQ, IPOPQ: length 2.
  - IJXX, ICALL: length 9.
  - IIRMOVQ, IRMMOVQ, IMRMOVQ: length 10.
  - icode > 4'hB: SINS, length 1.
  - If length ≤ 8 or imem_err_i is set, go to HOLD; else go to REQ1.
- REQ1: pulse the request with addr = pc+8. Go to WAIT1. WAIT1: on rvalid, capture buf1 and go to HOLD.
- Field extraction:
  - icode = byte0[7:4], ifun = byte0[3:0]; rA = byte1[7:4], rB = byte1[3:0] for lengths 2 and 10, else 4'hF.
  - valC: bytes 1..8 for length 9; bytes 2..9 for length 10, taking bytes 8..9 from buf1[15:0]; else 0.
- valP = pc + length, modulo 2^64 (wraps silently).
- stat priority:
  - imem_err_i on either read gives SADR. The fields from a faulting read are don't-care, but stat_o must be SADR.
  - Otherwise an invalid icode gives SINS.
  - Otherwise icode==IHALT gives SHLT.
  - Otherwise SAOK.
- HOLD: out_valid_o=1; all outputs stable until acceptance. On out_valid_o & out_ready_i:
  - stat SAOK: pc <= new_pc_i, go to REQ0.
  - stat not SAOK: go to STOP.
- STOP: out_valid_o=0, no requests. Only reset exits.
- imem_rvalid_i outside WAIT0/WAIT1 is ignored. At most one request is outstanding.

## Timing
- Reset values:
  - State REQ0; pc_o = RESET_PC, imem_addr_o = RESET_PC.
  - imem_req_o = 0, out_valid_o = 0, stat_o = SAOK.
  - All decoded fields, valC_o and valP_o = 0.
- The first request pulses in the first cycle after reset deassertion.
- Latency with 1-cycle memory, counted from the REQ0 cycle:
  - Lengths 1–8: out_valid_o at cycle +2.
  - Lengths 9/10: out_valid_o at cycle +4.
- Memory latency of N cycles adds N−1 per read.
- Acceptance cycle → REQ0 next cycle. Sustained throughput is 1 short instruction per 3 cycles.
- Reset asserted mid-operation (any state, including WAIT1) aborts immediately to reset values. A stale rvalid arriving in REQ0 is ignored.
- new_pc_i is only sampled in the acceptance cycle and may change freely otherwise.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds output instr_cnt_o [63:0], reset 0.
  - Increments on each accepted instruction, including the final non-SAOK one.
  - Wraps at 2^64.
- Undefined: port and counter absent, no other behaviour change.

## Structure
- icode constants (IHALT…IPOPQ) and stat codes belong in the shared define.v; add SAOK/SHLT/SADR/SINS there if missing.
- One sub-module: `insn_align`. It is combinational; from buf0, buf1 and length it produces rA, rB, valC and the SINS flag. The FSM, PC and buffers stay in fetch_unit.

## Test plan
- The "output reaches" entries below count cycles from the REQ0 cycle, as in Timing.
- NOP at PC 0 (byte 0x10), 1-cycle memory → one request, output at cycle 2: icode 1, rA=rB=F, valP=1, stat SAOK.
- IJXX `70` + 8 bytes 0x14 00..00 at PC 0 → two requests (addr 0, 8), output at cycle 4: valC=0x14, valP=9.
- IIRMOVQ `30 F2` + imm 0x0123456789ABCDEF at PC 6 → requests at 6 and 14; valC=0x0123456789ABCDEF, rB=2, valP=16.
- Byte 0xC0 → stat SINS, valP=PC+1. After acceptance: STOP, no further imem_req_o for 20 cycles.
- imem_err_i on the second read of IRMMOVQ → stat SADR, then STOP. IHALT → SHLT, then STOP.
- out_ready_i low for 5 cycles in HOLD → outputs stable. Assert rst_i during WAIT1 → reset values, then a fresh request at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared Y86-64 fetch definitions: icode and stat encodings, FSM state codes, instruction length lookup.
package fetch_unit_pkg;

  localparam logic [63:0] RESET_PC = 64'h0;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_e;

  localparam logic [2:0] S_REQ0  = 3'd0;
  localparam logic [2:0] S_WAIT0 = 3'd1;
  localparam logic [2:0] S_REQ1  = 3'd2;
  localparam logic [2:0] S_WAIT1 = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  // Unknown icodes are treated as one byte long so valP still advances.
  function automatic logic [3:0] insn_len(input logic [3:0] icode);
    case (icode)
      IHALT, INOP, IRET:             insn_len = 4'd1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:  insn_len = 4'd2;
      IJXX, ICALL:                   insn_len = 4'd9;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:     insn_len = 4'd10;
      default:                       insn_len = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port: request/address out, valid/data/error back.
interface fetch_unit_if;
  logic        req;
  logic [63:0] addr;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err;

  modport master (output req, output addr, input rvalid, input rdata, input err);
  modport slave  (input req, input addr, output rvalid, output rdata, output err);
endinterface

// File: rtl/fetch_unit_insn_align.sv
// Combinational field alignment: register specifiers, constant word and invalid-icode flag.
module insn_align
  import fetch_unit_pkg::*;
(
  input  logic [63:0] buf0_i,
  input  logic [15:0] buf1_lo_i,
  input  logic [3:0]  len_i,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic        sins_o
);

  assign sins_o = (buf0_i[7:4] > IPOPQ);

  // Only the low two bytes of the second word can belong to an instruction.
  always_comb begin
    rA_o   = RNONE;
    rB_o   = RNONE;
    valC_o = '0;
    if (len_i == 4'd2 || len_i == 4'd10) begin
      rA_o = buf0_i[15:12];
      rB_o = buf0_i[11:8];
    end
    if (len_i == 4'd9) begin
      valC_o = {buf1_lo_i[7:0], buf0_i[63:8]};
    end else if (len_i == 4'd10) begin
      valC_o = {buf1_lo_i, buf0_i[63:16]};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle Y86-64 fetch stage with registered valid/ready output.
// Optional FETCH_PERF_CNT_EN adds an accepted-instruction counter output.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master imem,
  input  logic [63:0]  new_pc_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [63:0]  pc_o,
  output logic [3:0]   icode_o,
  output logic [3:0]   ifun_o,
  output logic [3:0]   rA_o,
  output logic [3:0]   rB_o,
  output logic [63:0]  valC_o,
  output logic [63:0]  valP_o,
  output logic [2:0]   stat_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]  instr_cnt_o
`endif
);

  logic [2:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] buf0_q, buf0_d;
  logic [15:0] buf1_q, buf1_d;
  logic [3:0]  icode_q, ifun_q, rA_q, rB_q;
  logic [63:0] valC_q, valP_q;
  stat_e       stat_q, stat_n;
  logic        load_out;

  logic [63:0] word0;
  logic [15:0] word1;
  logic [3:0]  len;
  logic [3:0]  al_rA, al_rB;
  logic [63:0] al_valC;
  logic        al_sins;

  // Decode straight off the bus in the capture cycle so outputs register with the buffer.
  assign word0 = (state_q == S_WAIT0) ? imem.rdata : buf0_q;
  assign word1 = (state_q == S_WAIT1) ? imem.rdata[15:0] : buf1_q;
  assign len   = insn_len(word0[7:4]);

  insn_align u_align (
    .buf0_i    (word0),
    .buf1_lo_i (word1),
    .len_i     (len),
    .rA_o      (al_rA),
    .rB_o      (al_rB),
    .valC_o    (al_valC),
    .sins_o    (al_sins)
  );

  always_comb begin
    if (imem.err)                  stat_n = SADR;
    else if (al_sins)              stat_n = SINS;
    else if (word0[7:4] == IHALT)  stat_n = SHLT;
    else                           stat_n = SAOK;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    load_out = 1'b0;
    case (state_q)
      S_REQ0:  state_d = S_WAIT0;
      S_WAIT0: if (imem.rvalid) begin
        buf0_d = imem.rdata;
        if (len <= 4'd8 || imem.err) begin
          state_d  = S_HOLD;
          load_out = 1'b1;
        end else begin
          state_d = S_REQ1;
        end
      end
      S_REQ1:  state_d = S_WAIT1;
      S_WAIT1: if (imem.rvalid) begin
        buf1_d   = imem.rdata[15:0];
        state_d  = S_HOLD;
        load_out = 1'b1;
      end
      S_HOLD:  if (out_ready_i) begin
        if (stat_q == SAOK) begin
          pc_d    = new_pc_i;
          state_d = S_REQ0;
        end else begin
          state_d = S_STOP;
        end
      end
      S_STOP:  state_d = S_STOP;
      default: state_d = S_STOP;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_REQ0;
      pc_q    <= RESET_PC;
      buf0_q  <= '0;
      buf1_q  <= '0;
      icode_q <= '0;
      ifun_q  <= '0;
      rA_q    <= '0;
      rB_q    <= '0;
      valC_q  <= '0;
      valP_q  <= '0;
      stat_q  <= SAOK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      if (load_out) begin
        icode_q <= word0[7:4];
        ifun_q  <= word0[3:0];
        rA_q    <= al_rA;
        rB_q    <= al_rB;
        valC_q  <= al_valC;
        valP_q  <= pc_q + 64'(len);
        stat_q  <= stat_n;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                           cnt_q <= '0;
    else if (out_valid_o && out_ready_i) cnt_q <= cnt_q + 64'd1;
  end
  assign instr_cnt_o = cnt_q;
`endif

  // Reset gating keeps the request low while reset holds the FSM in REQ0.
  assign imem.req    = ((state_q == S_REQ0) || (state_q == S_REQ1)) && !rst_i;
  assign imem.addr   = (state_q == S_REQ1) ? pc_q + 64'd8 : pc_q;
  assign out_valid_o = (state_q == S_HOLD);
  assign pc_o        = pc_q;
  assign icode_o     = icode_q;
  assign ifun_o      = ifun_q;
  assign rA_o        = rA_q;
  assign rB_o        = rB_q;
  assign valC_o      = valC_q;
  assign valP_o      = valP_q;
  assign stat_o      = stat_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a byte-addressed memory model of configurable latency.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] new_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] pc, valC, valP;
  logic [3:0]  icode, ifun, rA, rB;
  logic [2:0]  stat;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] instr_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .imem        (imem_bus),
    .new_pc_i    (new_pc),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .pc_o        (pc),
    .icode_o     (icode),
    .ifun_o      (ifun),
    .rA_o        (rA),
    .rB_o        (rB),
    .valC_o      (valC),
    .valP_o      (valP),
    .stat_o      (stat)
`ifdef FETCH_PERF_CNT_EN
    ,
    .instr_cnt_o (instr_cnt)
`endif
  );

  // Memory model: requests seen mid-cycle, data returned lat cycles later in the second half-cycle.
  logic [7:0]  mem [0:255];
  int          lat = 1;
  int          err_at = -1;
  int          req_cnt = 0;
  int          pend = 0;
  logic [63:0] pend_addr = '0;
  logic        pend_err = 1'b0;
  logic [63:0] req_addr [0:7];

  initial begin
    imem_bus.rvalid = 1'b0;
    imem_bus.err    = 1'b0;
    imem_bus.rdata  = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
      req_cnt = 0;
      imem_bus.rvalid = 1'b0;
      imem_bus.err = 1'b0;
    end else begin
      imem_bus.rvalid = 1'b0;
      imem_bus.err = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          imem_bus.rvalid = 1'b1;
          imem_bus.err = pend_err;
          for (int b = 0; b < 8; b++)
            imem_bus.rdata[8*b +: 8] = mem[8'(pend_addr + 64'(b))];
        end
      end
      if (imem_bus.req) begin
        if (req_cnt < 8) req_addr[req_cnt] = imem_bus.addr;
        pend_err = (req_cnt == err_at);
        pend_addr = imem_bus.addr;
        pend = lat;
        req_cnt = req_cnt + 1;
      end
    end
  end

  task clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    lat = 1;
    err_at = -1;
  endtask

  // Leaves the bench one #1 into the REQ0 cycle that follows reset release.
  task do_reset();
    out_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task run_to_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task accept(input logic [63:0] np);
    new_pc = np;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    new_pc = 64'hDEAD_BEEF_0000_0000;
  endtask

  task test_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    vec_cnt++; if (pc !== 64'h0) begin err_cnt++; $display("FAIL reset_pc: got %h want %h", pc, 64'h0); end
    vec_cnt++; if (imem_bus.addr !== 64'h0) begin err_cnt++; $display("FAIL reset_addr: got %h want %h", imem_bus.addr, 64'h0); end
    vec_cnt++; if (imem_bus.req !== 1'b0) begin err_cnt++; $display("FAIL reset_req: got %b want 0", imem_bus.req); end
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vec_cnt++; if (stat !== 3'd1) begin err_cnt++; $display("FAIL reset_stat: got %0d want 1", stat); end
    vec_cnt++; if ({icode, ifun, rA, rB} !== 16'h0) begin err_cnt++; $display("FAIL reset_fields: got %h want 0000", {icode, ifun, rA, rB}); end
    vec_cnt++; if ({valC, valP} !== 128'h0) begin err_cnt++; $display("FAIL reset_valCP: got %h/%h want 0/0", valC, valP); end
    #1 rst = 1'b0;
    #1;
    vec_cnt++; if (imem_bus.req !== 1'b1) begin err_cnt++; $display("FAIL reset_first_req: got %b want 1", imem_bus.req); end
  endtask

  task test_nop();
    int cyc;
    clear_mem();
    mem[0] = 8'h10;
    do_reset();
    run_to_valid(cyc);
    vec_cnt++; if (cyc !== 2) begin err_cnt++; $display("FAIL nop_latency: got %0d want 2", cyc); end
    vec_cnt++; if (req_cnt !== 1) begin err_cnt++; $display("FAIL nop_reqs: got %0d want 1", req_cnt); end
    vec_cnt++; if (icode !== 4'h1 || ifun !== 4'h0) begin err_cnt++; $display("FAIL nop_icode: got %h%h want 10", icode, ifun); end
    vec_cnt++; if (rA !== 4'hF || rB !== 4'hF) begin err_cnt++; $display("FAIL nop_regs: got %h%h want FF", rA, rB); end
    vec_cnt++; if (valP !== 64'd1) begin err_cnt++; $display("FAIL nop_valP: got %h want 1", valP); end
    vec_cnt++; if (stat !== 3'd1) begin err_cnt++; $display("FAIL nop_stat: got %0d want 1", stat); end
    accept(64'h1);
  endtask

  task test_jxx();
    int cyc;
    clear_mem();
    mem[0] = 8'h70; mem[1] = 8'h14;
    do_reset();
    run_to_valid(cyc);
    vec_cnt++; if (cyc !== 4) begin err_cnt++; $display("FAIL jxx_latency: got %0d want 4", cyc); end
    vec_cnt++; if (req_cnt !== 2) begin err_cnt++; $display("FAIL jxx_reqs: got %0d want 2", req_cnt); end
    vec_cnt++; if (req_addr[0] !== 64'd0 || req_addr[1] !== 64'd8) begin err_cnt++; $display("FAIL jxx_addrs: got %h,%h want 0,8", req_addr[0], req_addr[1]); end
    vec_cnt++; if (valC !== 64'h14) begin err_cnt++; $display("FAIL jxx_valC: got %h want 14", valC); end
    vec_cnt++; if (valP !== 64'd9) begin err_cnt++; $display("FAIL jxx_valP: got %h want 9", valP); end
    vec_cnt++; if (rA !== 4'hF || rB !== 4'hF || icode !== 4'h7) begin err_cnt++; $display("FAIL jxx_fields: got %h %h%h want 7 FF", icode, rA, rB); end
  endtask

  task test_irmovq();
    int cyc;
    logic [63:0] imm;
    clear_mem();
    imm = 64'h0123_4567_89AB_CDEF;
    mem[0] = 8'h10;
    mem[6] = 8'h30; mem[7] = 8'hF2;
    for (int b = 0; b < 8; b++) mem[8 + b] = imm[8*b +: 8];
    do_reset();
    new_pc = 64'h55;
    run_to_valid(cyc);
    accept(64'd6);
    run_to_valid(cyc);
    vec_cnt++; if (cyc !== 4) begin err_cnt++; $display("FAIL irmovq_latency: got %0d want 4", cyc); end
    vec_cnt++; if (pc !== 64'd6) begin err_cnt++; $display("FAIL irmovq_pc: got %h want 6", pc); end
    vec_cnt++; if (req_addr[1] !== 64'd6 || req_addr[2] !== 64'd14) begin err_cnt++; $display("FAIL irmovq_addrs: got %h,%h want 6,e", req_addr[1], req_addr[2]); end
    vec_cnt++; if (valC !== 64'h0123_4567_89AB_CDEF) begin err_cnt++; $display("FAIL irmovq_valC: got %h want 0123456789abcdef", valC); end
    vec_cnt++; if (rA !== 4'hF || rB !== 4'h2) begin err_cnt++; $display("FAIL irmovq_regs: got %h%h want F2", rA, rB); end
    vec_cnt++; if (valP !== 64'd16) begin err_cnt++; $display("FAIL irmovq_valP: got %h want 10", valP); end
  endtask

  task test_stall();
    int cyc;
    clear_mem();
    mem[0] = 8'h10;
    lat = 2;
    do_reset();
    run_to_valid(cyc);
    vec_cnt++; if (cyc !== 3) begin err_cnt++; $display("FAIL stall_latency: got %0d want 3", cyc); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vec_cnt++; if (out_valid !== 1'b1 || valP !== 64'd1 || icode !== 4'h1) begin err_cnt++; $display("FAIL stall_hold%0d: got v=%b valP=%h icode=%h want 1/1/1", i, out_valid, valP, icode); end
    end
    vec_cnt++; if (req_cnt !== 1) begin err_cnt++; $display("FAIL stall_reqs: got %0d want 1", req_cnt); end
    accept(64'h1);
    vec_cnt++; if (out_valid !== 1'b0 || imem_bus.req !== 1'b1 || imem_bus.addr !== 64'h1) begin err_cnt++; $display("FAIL stall_next: got v=%b req=%b addr=%h want 0/1/1", out_valid, imem_bus.req, imem_bus.addr); end
  endtask

  task test_sins();
    int cyc, reqs;
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'hC0;
    do_reset();
    run_to_valid(cyc);
    accept(64'd1);
    run_to_valid(cyc);
    vec_cnt++; if (stat !== 3'd4) begin err_cnt++; $display("FAIL sins_stat: got %0d want 4", stat); end
    vec_cnt++; if (valP !== 64'd2) begin err_cnt++; $display("FAIL sins_valP: got %h want 2", valP); end
    accept(64'h40);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_bus.req || out_valid) reqs++;
      @(posedge clk); #1;
    end
    vec_cnt++; if (reqs !== 0) begin err_cnt++; $display("FAIL sins_stop: got %0d active cycles want 0", reqs); end
  endtask

  task test_adr();
    int cyc;
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'h12; mem[2] = 8'h08;
    err_at = 1;
    do_reset();
    run_to_valid(cyc);
    vec_cnt++; if (cyc !== 4) begin err_cnt++; $display("FAIL adr_latency: got %0d want 4", cyc); end
    vec_cnt++; if (stat !== 3'd3) begin err_cnt++; $display("FAIL adr_stat: got %0d want 3", stat); end
    accept(64'd10);
    repeat (5) @(posedge clk);
    #1;
    vec_cnt++; if (out_valid !== 1'b0 || req_cnt !== 2) begin err_cnt++; $display("FAIL adr_stop: got v=%b reqs=%0d want 0/2", out_valid, req_cnt); end
  endtask

  task test_halt();
    int cyc;
    clear_mem();
    do_reset();
    run_to_valid(cyc);
    vec_cnt++; if (stat !== 3'd2 || icode !== 4'h0) begin err_cnt++; $display("FAIL halt_stat: got %0d icode %h want 2 icode 0", stat, icode); end
    vec_cnt++; if (valP !== 64'd1) begin err_cnt++; $display("FAIL halt_valP: got %h want 1", valP); end
    accept(64'd1);
    repeat (5) @(posedge clk);
    #1;
    vec_cnt++; if (out_valid !== 1'b0 || req_cnt !== 1) begin err_cnt++; $display("FAIL halt_stop: got v=%b reqs=%0d want 0/1", out_valid, req_cnt); end
  endtask

  task test_reset_wait1();
    int cyc, n;
    clear_mem();
    mem[0] = 8'h70; mem[1] = 8'h14;
    lat = 3;
    do_reset();
    n = 0;
    while (req_cnt < 2 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    vec_cnt++; if (req_cnt !== 2) begin err_cnt++; $display("FAIL rstw1_reach: got %0d reqs want 2", req_cnt); end
    rst = 1'b1;
    #1;
    vec_cnt++; if (out_valid !== 1'b0 || imem_bus.req !== 1'b0 || pc !== 64'h0 || imem_bus.addr !== 64'h0) begin err_cnt++; $display("FAIL rstw1_abort: got v=%b req=%b pc=%h addr=%h want 0/0/0/0", out_valid, imem_bus.req, pc, imem_bus.addr); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vec_cnt++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 64'h0) begin err_cnt++; $display("FAIL rstw1_fresh: got req=%b addr=%h want 1/0", imem_bus.req, imem_bus.addr); end
    run_to_valid(cyc);
    vec_cnt++; if (cyc !== 8 || valC !== 64'h14) begin err_cnt++; $display("FAIL rstw1_refetch: got cyc=%0d valC=%h want 8/14", cyc, valC); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_nop();
    test_jxx();
    test_irmovq();
    test_stall();
    test_sins();
    test_adr();
    test_halt();
    test_reset_wait1();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
